// File: rtl/fpu_rs_arbiter.sv
// Shares one fixed-latency FP datapath among several requesters: round-robin
// grant, operand classification, local canonical-NaN bypass for NaN operands,
// and tag-routed responses back to the owning requester.

package fpu_pkg;

  typedef enum logic [1:0] {
    FMT_FP32 = 2'd0,
    FMT_FP64 = 2'd1,
    FMT_FP16 = 2'd2,
    FMT_BF16 = 2'd3
  } fp_format_e;

  // Per-operand classification
  typedef struct packed {
    logic is_neg;
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
    logic is_qnan;
  } fp_info_t;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FMT_FP32: return 8;
      FMT_FP64: return 11;
      FMT_FP16: return 5;
      default:  return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    case (fmt)
      FMT_FP32: return 23;
      FMT_FP64: return 52;
      FMT_FP16: return 10;
      default:  return 7;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

endpackage

// Combinational classifier for a set of operands
module fpu_utils_rsinfo #(
  parameter fpu_pkg::fp_format_e FP_FMT = fpu_pkg::fp_format_e'(0),
  parameter int unsigned RS_NUM = 3,
  localparam int unsigned FLEN = fpu_pkg::fp_width(FP_FMT)
) (
  input  logic [RS_NUM-1:0][FLEN-1:0]    i_rs,
  output fpu_pkg::fp_info_t [RS_NUM-1:0] o_info,
  output logic                           o_any_nan,
  output logic                           o_any_snan
);

  localparam int unsigned EXP_BITS = fpu_pkg::exp_bits(FP_FMT);
  localparam int unsigned MAN_BITS = fpu_pkg::man_bits(FP_FMT);

  logic [EXP_BITS-1:0] exp_f;
  logic [MAN_BITS-1:0] man_f;
  logic                exp_ones;
  logic                exp_zero;
  logic                man_zero;

  // Classify each operand and reduce the NaN flags across all of them
  always_comb begin
    o_info     = '0;
    o_any_nan  = 1'b0;
    o_any_snan = 1'b0;
    exp_f      = '0;
    man_f      = '0;
    exp_ones   = 1'b0;
    exp_zero   = 1'b0;
    man_zero   = 1'b0;
    for (int unsigned i = 0; i < RS_NUM; i++) begin
      exp_f    = i_rs[i][FLEN-2 -: EXP_BITS];
      man_f    = i_rs[i][MAN_BITS-1:0];
      exp_ones = &exp_f;
      exp_zero = ~|exp_f;
      man_zero = ~|man_f;
      o_info[i].is_neg       = i_rs[i][FLEN-1];
      o_info[i].is_normal    = ~exp_ones & ~exp_zero;
      o_info[i].is_subnormal = exp_zero & ~man_zero;
      o_info[i].is_zero      = exp_zero & man_zero;
      o_info[i].is_inf       = exp_ones & man_zero;
      o_info[i].is_nan       = exp_ones & ~man_zero;
      o_info[i].is_snan      = exp_ones & ~man_zero & ~man_f[MAN_BITS-1];
      o_info[i].is_qnan      = exp_ones & man_f[MAN_BITS-1];
      o_any_nan  = o_any_nan  | o_info[i].is_nan;
      o_any_snan = o_any_snan | o_info[i].is_snan;
    end
  end

endmodule

module fpu_rs_arbiter #(
  parameter fpu_pkg::fp_format_e FP_FMT = fpu_pkg::fp_format_e'(0),
  parameter int unsigned RS_NUM  = 3,
  parameter int unsigned REQ_NUM = 2,
  parameter int unsigned DP_LAT  = 3,
  localparam int unsigned FLEN   = fpu_pkg::fp_width(FP_FMT)
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic [REQ_NUM-1:0]                      i_req_valid,
  output logic [REQ_NUM-1:0]                      o_req_ready,
  input  logic [REQ_NUM-1:0][RS_NUM-1:0][FLEN-1:0] i_req_rs,
  output logic                                    o_dp_valid,
  output logic [RS_NUM-1:0][FLEN-1:0]             o_dp_rs,
  output fpu_pkg::fp_info_t [RS_NUM-1:0]          o_dp_rs_info,
  input  logic [FLEN-1:0]                         i_dp_result,
  input  logic                                    i_dp_nv,
  output logic [REQ_NUM-1:0]                      o_rsp_valid,
  output logic [FLEN-1:0]                         o_rsp_result,
  output logic                                    o_rsp_nv
);

  localparam int unsigned TAG_W    = $clog2(REQ_NUM);
  localparam int unsigned EXP_BITS = fpu_pkg::exp_bits(FP_FMT);
  localparam int unsigned MAN_BITS = fpu_pkg::man_bits(FP_FMT);
  localparam logic [FLEN-1:0] CANON_NAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

  // Arbiter state
  logic [TAG_W-1:0]   rr_q;
  logic [TAG_W-1:0]   rr_d;
  logic [REQ_NUM-1:0] busy_q;
  logic [REQ_NUM-1:0] eligible;
  logic [REQ_NUM-1:0] gnt;
  logic               gnt_any;
  logic [TAG_W-1:0]   gnt_tag;
  logic [TAG_W-1:0]   idx;

  // Granted operands and their classification
  logic [RS_NUM-1:0][FLEN-1:0]    gnt_rs;
  fpu_pkg::fp_info_t [RS_NUM-1:0] gnt_info;
  logic                           gnt_any_nan;
  logic                           gnt_any_snan;

  // Issue register
  logic                           iv_q;
  logic [TAG_W-1:0]               tag_q;
  logic [RS_NUM-1:0][FLEN-1:0]    rs_q;
  fpu_pkg::fp_info_t [RS_NUM-1:0] info_q;
  logic                           any_nan_q;
  logic                           any_snan_q;

  // Tag shift register tracking datapath occupancy
  logic [DP_LAT-1:0]            sr_v;
  logic [DP_LAT-1:0][TAG_W-1:0] sr_tag;
  logic                         tail_v;
  logic [TAG_W-1:0]             tail_tag;

  logic dispatch;
  logic bypass;
  logic stall;

  // Response register
  logic [REQ_NUM-1:0] rsp_valid_q;
  logic [FLEN-1:0]    rsp_result_q;
  logic               rsp_nv_q;

  assign tail_v   = sr_v[DP_LAT-1];
  assign tail_tag = sr_tag[DP_LAT-1];
  assign dispatch = iv_q & ~any_nan_q;
  assign bypass   = iv_q & any_nan_q;
  assign stall    = bypass & tail_v;

  // Round-robin search from rr over non-busy valid requesters
  always_comb begin
    eligible = i_req_valid & ~busy_q & {REQ_NUM{i_rst_n}};
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_tag  = '0;
    idx      = '0;
    rr_d     = rr_q;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      idx = TAG_W'((32'(rr_q) + i) % REQ_NUM);
      if (!gnt_any && !stall && eligible[idx]) begin
        gnt_any = 1'b1;
        gnt_tag = idx;
      end
    end
    if (gnt_any) begin
      gnt[gnt_tag] = 1'b1;
      rr_d         = TAG_W'((32'(gnt_tag) + 32'd1) % REQ_NUM);
    end
  end

  assign gnt_rs = i_req_rs[gnt_tag];

  fpu_utils_rsinfo #(
    .FP_FMT (FP_FMT),
    .RS_NUM (RS_NUM)
  ) u_rsinfo (
    .i_rs       (gnt_rs),
    .o_info     (gnt_info),
    .o_any_nan  (gnt_any_nan),
    .o_any_snan (gnt_any_snan)
  );

  // Round-robin pointer and one-outstanding-op busy bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q   <= '0;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= (busy_q & ~rsp_valid_q) | gnt;
    end
  end

  // Issue register: load on grant, hold a blocked bypass, otherwise free
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iv_q       <= 1'b0;
      tag_q      <= '0;
      rs_q       <= '0;
      info_q     <= '0;
      any_nan_q  <= 1'b0;
      any_snan_q <= 1'b0;
    end else if (gnt_any) begin
      iv_q       <= 1'b1;
      tag_q      <= gnt_tag;
      rs_q       <= gnt_rs;
      info_q     <= gnt_info;
      any_nan_q  <= gnt_any_nan;
      any_snan_q <= gnt_any_snan;
    end else if (!stall) begin
      iv_q       <= 1'b0;
    end
  end

  // Tag pipeline aligned to the datapath latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_v   <= '0;
      sr_tag <= '0;
    end else begin
      sr_v[0]   <= dispatch;
      sr_tag[0] <= tag_q;
      for (int unsigned i = 1; i < DP_LAT; i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
    end
  end

  // Response register: datapath retire has priority over the bypass
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_nv_q     <= 1'b0;
    end else if (tail_v) begin
      rsp_valid_q  <= REQ_NUM'(1) << tail_tag;
      rsp_result_q <= i_dp_result;
      rsp_nv_q     <= i_dp_nv;
    end else if (bypass) begin
      rsp_valid_q  <= REQ_NUM'(1) << tag_q;
      rsp_result_q <= CANON_NAN;
      rsp_nv_q     <= any_snan_q;
    end else begin
      rsp_valid_q  <= '0;
    end
  end

  assign o_req_ready  = gnt;
  assign o_dp_valid   = dispatch;
  assign o_dp_rs      = rs_q;
  assign o_dp_rs_info = info_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_nv     = rsp_nv_q;

endmodule

// File: tb/tb_fpu_rs_arbiter.sv
// Scoreboard bench for fpu_rs_arbiter: directed requests, a datapath model
// returning planned results after DP_LAT cycles, and a response monitor.

module tb_fpu_rs_arbiter;
  import fpu_pkg::*;

  localparam int unsigned REQ_NUM = 2;
  localparam int unsigned RS_NUM  = 3;
  localparam int unsigned DP_LAT  = 3;
  localparam int unsigned FLEN    = 32;

  localparam logic [95:0] OPS_A = {32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [95:0] OPS_B = {32'h40A00000, 32'h40800000, 32'h3F000000};

  typedef struct packed {
    logic [31:0] res;
    logic        nv;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [95:0] ops;
    logic [31:0] res;
    logic        nv;
  } dp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REQ_NUM-1:0]                        req_valid;
  logic [REQ_NUM-1:0]                        req_ready;
  logic [REQ_NUM-1:0][RS_NUM-1:0][FLEN-1:0]  req_rs;
  logic                                      dp_valid;
  logic [RS_NUM-1:0][FLEN-1:0]               dp_rs;
  fp_info_t [RS_NUM-1:0]                     dp_info;
  logic [FLEN-1:0]                           dp_result = '0;
  logic                                      dp_nv = 1'b0;
  logic [REQ_NUM-1:0]                        rsp_valid;
  logic [FLEN-1:0]                           rsp_result;
  logic                                      rsp_nv;

  fpu_rs_arbiter #(
    .RS_NUM  (RS_NUM),
    .REQ_NUM (REQ_NUM),
    .DP_LAT  (DP_LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_rs     (req_rs),
    .o_dp_valid   (dp_valid),
    .o_dp_rs      (dp_rs),
    .o_dp_rs_info (dp_info),
    .i_dp_result  (dp_result),
    .i_dp_nv      (dp_nv),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (rsp_result),
    .o_rsp_nv     (rsp_nv)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk    = 0;
  int n_pass   = 0;
  int rsp_seen = 0;

  exp_t q0[$];
  exp_t q1[$];
  dp_t  plan_q[$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  task automatic push_exp(input int r, input logic [31:0] res, input logic nv,
                          input logic [31:0] c);
    exp_t e;
    e.res = res;
    e.nv  = nv;
    e.cyc = c;
    if (r == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_plan(input logic [95:0] ops, input logic [31:0] res, input logic nv);
    dp_t d;
    d.ops = ops;
    d.res = res;
    d.nv  = nv;
    plan_q.push_back(d);
  endtask

  // Raise one request after dly cycles, wait for its grant, record expectations
  task automatic send(input int r, input int dly, input logic [95:0] ops,
                      input logic [31:0] res, input logic nv, input bit byp,
                      input int extra);
    bit got;
    logic [31:0] t;
    repeat (dly) @(posedge clk);
    @(posedge clk);
    #1;
    req_rs[r]    = ops;
    req_valid[r] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL grant_timeout req%0d: got no grant, expected one within 40 cycles", r);
    end else begin
      t = cyc;
      if (byp) push_exp(r, res, nv, t + 32'd2 + 32'(extra));
      else begin
        push_exp(r, res, nv, t + 32'd2 + 32'(DP_LAT) + 32'(extra));
        push_plan(ops, res, nv);
      end
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  // Wait for all outstanding expectations to be consumed
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && plan_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_chk++;
      $display("FAIL drain_timeout: got q0=%0d q1=%0d plan=%0d pending, expected 0",
               q0.size(), q1.size(), plan_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Datapath model: returns the planned result DP_LAT cycles after issue
  bit  pv[DP_LAT+1];
  dp_t pd[DP_LAT+1];
  dp_t dpe;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= DP_LAT; k++) pv[k] = 1'b0;
    end else begin
      for (int k = DP_LAT; k > 0; k--) begin
        pv[k] = pv[k-1];
        pd[k] = pd[k-1];
      end
      pv[0] = dp_valid;
      if (dp_valid) begin
        if (plan_q.size() == 0) begin
          pv[0] = 1'b0;
          n_chk++;
          $display("FAIL unexpected_dp_valid: got o_dp_valid=1, expected 0");
        end else begin
          dpe   = plan_q.pop_front();
          pd[0] = dpe;
          chk("dp_rs", dp_rs, dpe.ops);
          chk("dp_info_normal",
              {dp_info[2].is_normal, dp_info[1].is_normal, dp_info[0].is_normal}, 3'b111);
        end
      end
    end
    if (pv[DP_LAT]) begin
      dp_result = pd[DP_LAT].res;
      dp_nv     = pd[DP_LAT].nv;
    end else begin
      dp_result = $urandom;
      dp_nv     = 1'($urandom_range(0, 1));
    end
  end

  // Response monitor: pop the owner's expectation and compare
  exp_t me;
  bit   mhave;
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      rsp_seen++;
      chk("rsp_onehot", 96'($onehot(rsp_valid)), 96'd1);
      mhave = 1'b0;
      if (rsp_valid[1]) begin
        if (q1.size() != 0) begin me = q1.pop_front(); mhave = 1'b1; end
      end else if (q0.size() != 0) begin
        me = q0.pop_front();
        mhave = 1'b1;
      end
      if (!mhave) begin
        n_chk++;
        $display("FAIL unexpected_rsp: got o_rsp_valid=%b, expected no response", rsp_valid);
      end else begin
        chk("rsp_result", rsp_result, me.res);
        chk("rsp_nv", rsp_nv, me.nv);
        chk("rsp_cycle", cyc, me.cyc);
      end
    end
  end

  int          gr[4];
  logic [31:0] gc[4];
  int          ng;
  int          seen0;
  logic [REQ_NUM-1:0] g;
  int          exp_r[4]   = '{0, 1, 0, 1};
  logic [31:0] exp_off[4] = '{32'd0, 32'd1, 32'd6, 32'd7};
  logic [31:0] rr_res[4]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  initial begin
    req_valid = 2'b11;
    req_rs    = {OPS_B, OPS_A};
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_nv", rsp_nv, 0);
    chk("rst_dp_rs", dp_rs, 0);
    chk("rst_dp_info", dp_info, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with both requesters held valid from reset
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      g = req_ready & req_valid;
      if (g != '0) begin
        gr[ng] = g[1] ? 1 : 0;
        gc[ng] = cyc;
        push_exp(gr[ng], rr_res[ng], 1'b0, cyc + 32'd2 + 32'(DP_LAT));
        push_plan(g[1] ? OPS_B : OPS_A, rr_res[ng], 1'b0);
        ng++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("rr_grant_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) begin
        chk($sformatf("rr_grant_req%0d", k), gr[k], exp_r[k]);
        if (k > 0) chk($sformatf("rr_grant_cyc%0d", k), gc[k] - gc[0], exp_off[k]);
      end
    end
    drain();

    // Single normal request through the datapath
    send(0, 0, OPS_A, 32'h40E00000, 1'b0, 1'b0, 0);
    drain();
    // sNaN in rs1: bypass, invalid raised
    send(1, 0, {32'h40400000, 32'h7F800001, 32'h3F800000}, 32'h7FC00000, 1'b1, 1'b1, 0);
    drain();
    // qNaN in rs1: bypass, no invalid
    send(0, 0, {32'h40400000, 32'h7FC00001, 32'h3F800000}, 32'h7FC00000, 1'b0, 1'b1, 0);
    drain();
    // Mixed negative sNaN and qNaN: sNaN wins the invalid flag
    send(1, 0, {32'hFF800010, 32'h3F800000, 32'h7FC00000}, 32'h7FC00000, 1'b1, 1'b1, 0);
    drain();
    // Datapath-reported invalid flag passes through
    send(1, 0, OPS_B, 32'h7FC00000, 1'b1, 1'b0, 0);
    drain();

    // Collision: req1 bypass lands on req0 retire cycle and slips by one
    fork
      send(0, 0, OPS_A, 32'h41100000, 1'b0, 1'b0, 0);
      send(1, 3, {32'h3F800000, 32'h40000000, 32'h7FC00001}, 32'h7FC00000, 1'b0, 1'b1, 1);
    join
    drain();

    // Reset with two operations in flight
    fork
      send(0, 0, OPS_A, 32'h40000000, 1'b0, 1'b0, 0);
      send(1, 0, OPS_B, 32'h40400000, 1'b0, 1'b0, 0);
    join
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_dp_valid", dp_valid, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_result", rsp_result, 0);
    chk("mid_rst_rsp_nv", rsp_nv, 0);
    chk("mid_rst_dp_rs", dp_rs, 0);
    q0.delete();
    q1.delete();
    plan_q.delete();
    seen0 = rsp_seen;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    chk("no_stale_rsp", rsp_seen - seen0, 0);

    // Normal operation resumes after reset
    send(1, 0, OPS_B, 32'h40490FDB, 1'b0, 1'b0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
